// File: rtl/bit_packer_pkg.sv
// Shared definitions for the bit packer and its downstream unpacker:
// word/field geometry, accumulator sizing, output state encoding and
// the field masking helper.
package bit_packer_pkg;

  localparam int WORD_W  = 32;
  localparam int FIELD_W = 15;
  localparam int LEN_W   = 4;
  localparam int ACC_W   = WORD_W + FIELD_W;   // 47 bits: residue <=31 plus one field
  localparam int CNT_W   = $clog2(ACC_W + 1);  // holds 0..47

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Mask keeping the low 'len' bits of a field; len=0 gives all zeros.
  function automatic logic [FIELD_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [FIELD_W:0] m;
    m = ((FIELD_W+1)'(1) << len) - (FIELD_W+1)'(1);
    return m[FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/bit_packer.sv
// Packs 1..15-bit fields MSB-first into 32-bit words. A left-justified
// accumulator collects field bits; complete words (and zero-padded
// residue on flush) go to a registered output stage that holds words
// while the downstream asserts fullin.
//
// Handshake: a request (pushin with lenin!=0, or flush) is consumed at a
// rising edge only when readyout=1 during that cycle; otherwise it is
// dropped and err latches. pushout is a one-cycle strobe qualifying
// dataout; a word is only released at an edge where fullin=0.
module bit_packer
  import bit_packer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                pushin,
  input  logic [LEN_W-1:0]    lenin,
  input  logic [FIELD_W-1:0]  datain,
  input  logic                flush,
  input  logic                fullin,
  output logic                readyout,
  output logic                pushout,
  output logic [WORD_W-1:0]   dataout,
  output logic                err,
  output logic                state_dbg
);

  state_t              state, state_nx;
  logic [ACC_W-1:0]    acc, acc_nx;
  logic [CNT_W-1:0]    count, count_nx;
  logic [WORD_W-1:0]   hold_word, hold_nx;
  logic [WORD_W-1:0]   pend_word, pend_nx;
  logic                pend_valid, pend_valid_nx;
  logic [WORD_W-1:0]   dataout_nx;
  logic                pushout_nx, err_nx;

  // Datapath intermediates
  logic                accept, do_push, do_flush;
  logic [ACC_W-1:0]    field_ext, acc_app, acc_res;
  logic [CNT_W-1:0]    cnt_app, cnt_res, shamt;
  logic                full_word, flush_word, have_first, have_second;
  logic [WORD_W-1:0]   first_word, res_word;

  assign accept    = (state == IDLE);
  assign readyout  = accept;
  assign state_dbg = state;

  // Registered state; synchronous active-low reset discards everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      hold_word  <= '0;
      pend_word  <= '0;
      pend_valid <= 1'b0;
      dataout    <= '0;
      pushout    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      count      <= count_nx;
      hold_word  <= hold_nx;
      pend_word  <= pend_nx;
      pend_valid <= pend_valid_nx;
      dataout    <= dataout_nx;
      pushout    <= pushout_nx;
      err        <= err_nx;
    end
  end

  // Aligner/accumulator, word extraction and output state machine.
  always_comb begin
    state_nx      = state;
    acc_nx        = acc;
    count_nx      = count;
    hold_nx       = hold_word;
    pend_nx       = pend_word;
    pend_valid_nx = pend_valid;
    dataout_nx    = dataout;
    pushout_nx    = 1'b0;
    err_nx        = err | (!accept && (flush || (pushin && (lenin != '0))));

    do_push  = accept && pushin;
    do_flush = accept && flush;

    // Append: place masked field bits directly below the valid bits.
    field_ext = {{(ACC_W-FIELD_W){1'b0}}, (do_push ? (datain & len_mask(lenin)) : '0)};
    cnt_app   = count + (do_push ? CNT_W'(lenin) : '0);
    shamt     = CNT_W'(ACC_W) - cnt_app;
    acc_app   = acc | (field_ext << shamt);

    // At most one full word per append since residue <=31 and field <=15.
    full_word = (cnt_app >= CNT_W'(WORD_W));
    acc_res   = full_word ? (acc_app << WORD_W) : acc_app;
    cnt_res   = full_word ? (cnt_app - CNT_W'(WORD_W)) : cnt_app;

    // Flush emits the residue left-justified; bits below count are zero.
    flush_word = do_flush && (cnt_res != '0);
    res_word   = acc_res[ACC_W-1 -: WORD_W];

    first_word  = full_word ? acc_app[ACC_W-1 -: WORD_W] : res_word;
    have_first  = full_word || flush_word;
    have_second = full_word && flush_word;

    if (accept) begin
      acc_nx   = do_flush ? '0 : acc_res;
      count_nx = do_flush ? '0 : cnt_res;
      if (have_first) begin
        if (!fullin) begin
          dataout_nx = first_word;
          pushout_nx = 1'b1;
          if (have_second) begin
            hold_nx  = res_word;
            state_nx = HOLD;
          end
        end else begin
          hold_nx  = first_word;
          state_nx = HOLD;
          if (have_second) begin
            pend_nx       = res_word;
            pend_valid_nx = 1'b1;
          end
        end
      end
    end else begin
      // HOLD: release the held word at the first edge with fullin=0.
      if (!fullin) begin
        dataout_nx = hold_word;
        pushout_nx = 1'b1;
        if (pend_valid) begin
          hold_nx       = pend_word;
          pend_valid_nx = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: directed vector table, hand-written HOLD and
// reset sequences, and randomized traffic, all compared against a
// bit-queue reference model.
module tb_bit_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flush;
  logic        fullin;
  logic        readyout;
  logic        pushout;
  logic [31:0] dataout;
  logic        err;
  logic        state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          bitq[$];
  logic [31:0] exp_q[$];
  logic        m_pushout;
  logic [31:0] m_dataout;
  logic        m_err;
  logic        m_ready;

  typedef struct packed {
    logic        p;
    logic [3:0]  l;
    logic [14:0] d;
    logic        f;
    logic        fi;
    logic        exp_po;
    logic [31:0] exp_do;
  } vec_t;

  vec_t tbl[$];

  bit_packer dut (
    .clock     (clock),
    .reset     (reset),
    .pushin    (pushin),
    .lenin     (lenin),
    .datain    (datain),
    .flush     (flush),
    .fullin    (fullin),
    .readyout  (readyout),
    .pushout   (pushout),
    .dataout   (dataout),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pop_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], logic'(bitq.pop_front())};
    return w;
  endfunction

  // Model of one rising edge: bits go through a plain queue; words wait
  // in exp_q until an edge with fullin=0 delivers one.
  task automatic model_edge(input logic p, input logic [3:0] l, input logic [14:0] d,
                            input logic f, input logic fi);
    bit ready;
    ready = (exp_q.size() == 0);
    if (!ready && (f || (p && l != 0))) m_err = 1'b1;
    if (ready) begin
      if (p) for (int i = int'(l) - 1; i >= 0; i--) bitq.push_back(d[i]);
      if (bitq.size() >= 32) exp_q.push_back(pop_word());
      if (f && bitq.size() > 0) begin
        while (bitq.size() < 32) bitq.push_back(1'b0);
        exp_q.push_back(pop_word());
      end
    end
    m_pushout = 1'b0;
    if (!fi && exp_q.size() > 0) begin
      m_dataout = exp_q.pop_front();
      m_pushout = 1'b1;
    end
    m_ready = (exp_q.size() == 0);
  endtask

  task automatic model_reset();
    bitq.delete();
    exp_q.delete();
    m_pushout = 1'b0;
    m_dataout = '0;
    m_err     = 1'b0;
    m_ready   = 1'b1;
  endtask

  task automatic compare_model();
    check("pushout", 32'(pushout), 32'(m_pushout));
    check("dataout", dataout, m_dataout);
    check("readyout", 32'(readyout), 32'(m_ready));
    check("err", 32'(err), 32'(m_err));
  endtask

  // Driver: apply inputs for one cycle, update model, check after edge.
  task automatic step(input logic p, input logic [3:0] l, input logic [14:0] d,
                      input logic f, input logic fi);
    pushin = p; lenin = l; datain = d; flush = f; fullin = fi;
    @(posedge clock);
    model_edge(p, l, d, f, fi);
    #1;
    compare_model();
  endtask

  task automatic reset_step();
    reset = 1'b0;
    pushin = 1'b0; lenin = '0; datain = '0; flush = 1'b0; fullin = 1'b0;
    @(posedge clock);
    model_reset();
    #1;
    compare_model();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; pushin = 1'b0; lenin = '0; datain = '0; flush = 1'b0; fullin = 1'b0;
    model_reset();

    // Reset state
    reset_step();
    check("rst_pushout", 32'(pushout), 32'h0);
    check("rst_dataout", dataout, 32'h0);
    check("rst_readyout", 32'(readyout), 32'h1);
    check("rst_err", 32'(err), 32'h0);

    // Directed vectors: each row is one edge and the strobe it must yield.
    tbl.push_back('{1'b1, 4'd8,  15'h00AB, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'd8,  15'h00AB, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'd8,  15'h00AB, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'd8,  15'h00AB, 1'b0, 1'b0, 1'b1, 32'hABABABAB});
    tbl.push_back('{1'b0, 4'd0,  15'h0000, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'd15, 15'h7FFF, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'd15, 15'h7FFF, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'd15, 15'h7FFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF});
    tbl.push_back('{1'b0, 4'd0,  15'h0000, 1'b1, 1'b0, 1'b1, 32'hFFF80000});
    tbl.push_back('{1'b1, 4'd4,  15'h001F, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 4'd0,  15'h0000, 1'b1, 1'b0, 1'b1, 32'hF0000000});
    tbl.push_back('{1'b0, 4'd0,  15'h0000, 1'b1, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'd15, 15'h1234, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'd5,  15'h000A, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 4'd15, 15'h7FFF, 1'b1, 1'b0, 1'b1, 32'h2468AFFF});
    tbl.push_back('{1'b0, 4'd0,  15'h0000, 1'b0, 1'b0, 1'b1, 32'hE0000000});
    tbl.push_back('{1'b1, 4'd0,  15'h7FFF, 1'b0, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 4'd0,  15'h0000, 1'b1, 1'b0, 1'b0, 32'h0});

    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].p, tbl[i].l, tbl[i].d, tbl[i].f, tbl[i].fi);
      check($sformatf("tbl%0d_pushout", i), 32'(pushout), 32'(tbl[i].exp_po));
      if (tbl[i].exp_po) check($sformatf("tbl%0d_dataout", i), dataout, tbl[i].exp_do);
    end
    check("noop_err", 32'(err), 32'h0);

    // Backpressure: word completes under fullin, push during HOLD is dropped.
    step(1'b1, 4'd8, 15'h005C, 1'b0, 1'b0);
    step(1'b1, 4'd8, 15'h005C, 1'b0, 1'b0);
    step(1'b1, 4'd8, 15'h005C, 1'b0, 1'b0);
    step(1'b1, 4'd8, 15'h005C, 1'b0, 1'b1);
    check("hold_readyout", 32'(readyout), 32'h0);
    check("hold_pushout", 32'(pushout), 32'h0);
    step(1'b1, 4'd8, 15'h0011, 1'b0, 1'b1);
    check("hold_err", 32'(err), 32'h1);
    check("hold_readyout2", 32'(readyout), 32'h0);
    step(1'b0, 4'd0, 15'h0000, 1'b0, 1'b0);
    check("release_pushout", 32'(pushout), 32'h1);
    check("release_dataout", dataout, 32'h5C5C5C5C);
    check("release_readyout", 32'(readyout), 32'h1);
    step(1'b0, 4'd0, 15'h0000, 1'b0, 1'b0);
    check("strobe_one_cycle", 32'(pushout), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'd8, 15'h0012, 1'b0, 1'b0);
    check("after_drop_dataout", dataout, 32'h12121212);

    // Split flush under fullin: both words held, delivered in order.
    step(1'b1, 4'd15, 15'h1234, 1'b0, 1'b0);
    step(1'b1, 4'd5,  15'h000A, 1'b0, 1'b0);
    step(1'b1, 4'd15, 15'h7FFF, 1'b1, 1'b1);
    step(1'b0, 4'd0,  15'h0000, 1'b0, 1'b0);
    check("split_held_w1", dataout, 32'h2468AFFF);
    step(1'b0, 4'd0,  15'h0000, 1'b0, 1'b1);
    check("split_stall", 32'(pushout), 32'h0);
    step(1'b0, 4'd0,  15'h0000, 1'b0, 1'b0);
    check("split_held_w2", dataout, 32'hE0000000);

    // Reset while in HOLD with residue in the accumulator.
    step(1'b1, 4'd15, 15'h7FFF, 1'b0, 1'b0);
    step(1'b1, 4'd15, 15'h7FFF, 1'b0, 1'b0);
    step(1'b1, 4'd15, 15'h7FFF, 1'b0, 1'b1);
    reset_step();
    check("rst_hold_pushout", 32'(pushout), 32'h0);
    check("rst_hold_dataout", dataout, 32'h0);
    check("rst_hold_readyout", 32'(readyout), 32'h1);
    check("rst_hold_err", 32'(err), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'd8, 15'h00AB, 1'b0, 1'b0);
    check("rst_restart_dataout", dataout, 32'hABABABAB);
    check("rst_restart_pushout", 32'(pushout), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(3, 0) != 0),
           4'($urandom_range(15, 0)),
           15'($urandom_range(32767, 0)),
           logic'($urandom_range(7, 0) == 0),
           logic'($urandom_range(3, 0) == 0));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 15'h0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
